// File: rtl/cut_equiv_sequencer.sv
// cut_equiv_sequencer
// Sweeps a shared input bus through every vector, holds each vector for a
// programmable settle time, then compares a golden CUT against a CUT under
// test and accumulates mismatch statistics for a host start/done handshake.
module cut_equiv_sequencer #(
    parameter int N_IN   = 5,
    parameter int N_OUT  = 11,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  cut_x,
    input  logic [N_OUT-1:0] ref_f,
    input  logic [N_OUT-1:0] dut_f,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic [N_IN:0]    mismatch_cnt,
    output logic [N_OUT-1:0] diff_mask,
    output logic             fail_valid,
    output logic [N_IN-1:0]  first_fail_vec
);

    // Settle counter needs to reach SETTLE; keep at least one bit so SETTLE=0 is legal.
    localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [SW-1:0]   S_LAST = SW'(SETTLE);
    localparam logic [N_IN-1:0] V_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   v_q, v_d;
    logic [SW-1:0]     s_q, s_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              equal_q, equal_d;
    logic [N_IN:0]     mismatch_cnt_q, mismatch_cnt_d;
    logic [N_OUT-1:0]  diff_mask_q, diff_mask_d;
    logic              fail_valid_q, fail_valid_d;
    logic [N_IN-1:0]   first_fail_vec_q, first_fail_vec_d;
    logic [N_OUT-1:0]  diff;

    // Next-state and statistics update; the CUT outputs are only looked at on the sample cycle.
    always_comb begin
        state_d          = state_q;
        v_d              = v_q;
        s_d              = s_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        equal_d          = equal_q;
        mismatch_cnt_d   = mismatch_cnt_q;
        diff_mask_d      = diff_mask_q;
        fail_valid_d     = fail_valid_q;
        first_fail_vec_d = first_fail_vec_q;
        diff             = ref_f ^ dut_f;

        case (state_q)
            ST_IDLE: begin
                // start beats a simultaneous abort simply because abort is not looked at here
                if (start) begin
                    state_d          = ST_RUN;
                    v_d              = '0;
                    s_d              = '0;
                    busy_d           = 1'b1;
                    equal_d          = 1'b0;
                    mismatch_cnt_d   = '0;
                    diff_mask_d      = '0;
                    fail_valid_d     = 1'b0;
                    first_fail_vec_d = '0;
                end
            end

            ST_RUN: begin
                if (abort) begin
                    // Abort wins over a coincident sample: partial results are left untouched.
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (s_q != S_LAST) begin
                    s_d = s_q + SW'(1);
                end else begin
                    diff_mask_d = diff_mask_q | diff;
                    if (diff != '0) begin
                        mismatch_cnt_d = mismatch_cnt_q + (N_IN + 1)'(1);
                        if (!fail_valid_q) begin
                            fail_valid_d     = 1'b1;
                            first_fail_vec_d = v_q;
                        end
                    end
                    if (v_q == V_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        v_d = v_q + N_IN'(1);
                        s_d = '0;
                    end
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                equal_d = (mismatch_cnt_q == '0);
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears every observable output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            v_q              <= '0;
            s_q              <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            equal_q          <= 1'b0;
            mismatch_cnt_q   <= '0;
            diff_mask_q      <= '0;
            fail_valid_q     <= 1'b0;
            first_fail_vec_q <= '0;
        end else begin
            state_q          <= state_d;
            v_q              <= v_d;
            s_q              <= s_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            equal_q          <= equal_d;
            mismatch_cnt_q   <= mismatch_cnt_d;
            diff_mask_q      <= diff_mask_d;
            fail_valid_q     <= fail_valid_d;
            first_fail_vec_q <= first_fail_vec_d;
        end
    end

    assign cut_x          = v_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign equal          = equal_q;
    assign mismatch_cnt   = mismatch_cnt_q;
    assign diff_mask      = diff_mask_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_vec = first_fail_vec_q;

endmodule

// File: doc/cut_equiv_sequencer.md
# cut_equiv_sequencer

Sequential equivalence-check controller for a pair of small combinational benchmark circuits, for example an original netlist and its balanced re-synthesis. It walks the shared input bus exhaustively through all 2^N_IN vectors and waits a programmable settle time on each one. It then compares the two N_OUT-bit output buses and accumulates mismatch statistics, which a host reads through a start/done handshake. It is the test harness that sits between the dataset generator's verification flow and any two CUT instances with identical port lists.

## Interface
- N_IN, 5, width of the shared CUT input bus (1..16)
- N_OUT, 11, width of each CUT output bus (1..64)
- SETTLE, 1, extra cycles each vector is held before sampling (0..15)

- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a sweep; honoured only in IDLE
- abort  input  1  cancel a running sweep
- cut_x  output  N_IN  vector driven to both CUTs (x0 = bit 0)
- ref_f  input  N_OUT  golden CUT outputs (f1 = bit 0)
- dut_f  input  N_OUT  CUT-under-test outputs
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse when a sweep completes normally
- equal  output  1  last completed sweep had zero mismatches
- mismatch_cnt  output  N_IN+1  number of vectors with any output difference
- diff_mask  output  N_OUT  OR over all sampled vectors of ref_f ^ dut_f
- fail_valid  output  1  at least one mismatch recorded
- first_fail_vec  output  N_IN  lowest vector that mismatched

## Operation
- Reset state: IDLE. All outputs are 0: busy, done, equal, cut_x, mismatch_cnt, diff_mask, fail_valid, first_fail_vec.
- States are IDLE, RUN and DONE. Internal registers:
  - vector counter v, N_IN bits
  - settle counter s, width ceil(log2(SETTLE+1)), minimum 1
- IDLE to RUN on start:
  - clears mismatch_cnt, diff_mask, fail_valid, first_fail_vec and equal
  - sets v=0, s=0, busy=1
- RUN, each cycle:
  - If s < SETTLE: s increments.
  - If s == SETTLE: this is the sample cycle. Let d = ref_f ^ dut_f.
    - diff_mask |= d.
    - If d != 0: mismatch_cnt increments. If fail_valid is 0, first_fail_vec = v and fail_valid = 1.
    - Then if v == 2^N_IN-1, go to DONE. Otherwise v increments and s = 0.
- DONE: done=1 for exactly one cycle, equal = (mismatch_cnt == 0), busy=0, then IDLE.
- cut_x always equals v. It holds its last value in IDLE and DONE.
- mismatch_cnt cannot saturate: its maximum is 2^N_IN, which fits in N_IN+1 bits.
- Results stay stable from DONE until the next accepted start.
- abort in RUN: next state IDLE, busy=0, done not pulsed, equal stays 0. Partial statistics remain visible.
- abort has no effect in IDLE or DONE.
- start while busy is ignored. start in the DONE cycle is ignored.
- abort and start in the same IDLE cycle: start wins.
- rst overrides everything, including mid-sweep: next cycle all outputs are at reset values and the state is IDLE.
- Comparison is purely on the sample cycle. Glitches on ref_f/dut_f during settle cycles are never observed.

## Timing
- cut_x, busy and all statistics are registered. There are no combinational paths from inputs to outputs.
- Start accepted at edge k:
  - cut_x=0 and busy=1 are visible after edge k.
  - Vector v is sampled on edge k+1+v*(SETTLE+1)+SETTLE.
- RUN lasts 2^N_IN*(SETTLE+1) cycles. done is high in the following cycle.
- With defaults: 64 RUN cycles. done is high after edge k+65. busy falls with done. equal is valid in the same cycle as done.
- With SETTLE=0, one vector per cycle; cut_x changes every cycle.
- Earliest restart: start in the cycle after done (IDLE).

## Test plan
- Identity check, defaults, dut_f tied to ref_f (any 11-bit function of cut_x):
  - done pulses exactly once, 65 cycles after the start edge
  - equal=1, mismatch_cnt=0, diff_mask=0, fail_valid=0
- Single-fault injection, dut_f = ref_f ^ 11'h008 only when cut_x==17:
  - mismatch_cnt=1, diff_mask=11'h008, fail_valid=1, first_fail_vec=17, equal=0
- Multi-fault, SETTLE=0, bit 0 flipped for every odd vector and bit 10 flipped for vector 4:
  - mismatch_cnt=17, diff_mask=11'h401, first_fail_vec=1
  - done 33 cycles after the start edge
- Settle filtering, SETTLE=2, dut_f corrupted only during non-sample cycles:
  - equal=1, mismatch_cnt=0
  - each cut_x value is held 3 cycles
- Abort at cycle 20 of RUN, with a fault on vector 3:
  - busy drops the next cycle and done never pulses
  - mismatch_cnt=1, first_fail_vec=3
  - A new start then clears the results and completes a full sweep.
- Start pulsed repeatedly while busy, then rst asserted mid-sweep:
  - the extra starts are ignored and the sweep length is unchanged
  - after rst, all outputs are 0 and the block is in IDLE on the next cycle
